regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port general register file with write-through bypass and a per-register pending-write scoreboard, for the pipelined CPU datapath. Decode reads operands and gets a busy flag per port to drive stall logic. Issue allocates destination registers. Writeback writes data and retires the allocation. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; depth = 2**ADDR_W
- NREAD, 2: number of read ports (1..4)
- CNT_W, 2: pending-write counter width; max outstanding writes per register = 2**CNT_W-1

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_addr  in  NREAD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, bypassed
- rd_busy  out  NREAD  operand still pending
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- wr_pc  in  32  PC of the writing instruction (trace only)
- alloc_valid  in  1  issue marks a destination pending
- alloc_addr  in  ADDR_W  destination being allocated
- alloc_ready  out  1  allocation accepted this cycle
- flush  in  1  pipeline flush; clears all pending counters

## Operation
- Storage: 2**ADDR_W x DATA_W. Reset clears all entries and all counters to 0.
- Write: wr_en && wr_addr!=0 sets mem[wr_addr]<=wr_data at the posedge. A write to register 0 is discarded.
- Read, per port: rd_data = 0 if addr==0. Otherwise it is wr_data if wr_en && wr_addr==addr (write-through bypass). Otherwise it is mem[addr].
- Counter cnt[r], per register:
  - increments on an accepted alloc to r
  - decrements on wr_en to r
  - both in the same cycle: cnt[r] unchanged
  - wr_en while cnt==0: no underflow; cnt stays 0; the data is still written
- alloc_ready = (alloc_addr==0) || cnt[alloc_addr]!=max || (wr_en && wr_addr==alloc_addr). A refused alloc changes no state. An alloc to register 0 is accepted and ignored.
- rd_busy[i] = addr!=0 && cnt[addr]!=0, except it is 0 when cnt[addr]==1 && wr_en && wr_addr==addr (the bypass supplies the final value).
- flush: all cnt<=0 at the posedge. flush wins over a simultaneous alloc or writeback counter update. Writeback data is still written.

## Timing
- Reads, bypass, rd_busy and alloc_ready are combinational (0-cycle latency).
- Writes and counter updates are visible on the cycle after the posedge.
- Reset has priority over everything: mem, cnt and all counter updates are cleared. Immediately after reset, rd_data=0, rd_busy=0 and alloc_ready=1 for every address.
- Reset asserted mid-operation discards all pending state. A wr_en in the same cycle as reset is lost.

## Configuration
- REGFILE_TRACE_EN defined: every effective write (wr_en, wr_addr!=0, not in reset) prints `$display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data)` at the posedge.
- REGFILE_TRACE_EN undefined: there is no $display. wr_pc is unused but the port stays.

## Structure
- Package regfile_pkg holds:
  - default DATA_W, ADDR_W and CNT_W constants
  - a typedef for the register address
  - a typedef for the counter
- Sub-module regfile_scoreboard holds the cnt array, alloc_ready and the busy computation. The top holds storage, bypass and trace.

## Test plan
- Reset, then read every address on all ports -> rd_data=0, rd_busy=0, alloc_ready=1.
- wr_en to $5 with 0x1234_5678 while port0 reads $5 in the same cycle -> rd_data0=0x1234_5678 in that cycle and afterwards. Write 0xFFFF_FFFF to $0 -> port reads 0.
- alloc $3, then read $3 -> rd_busy=1. Writeback $3 the next cycle -> rd_busy=0 in the writeback cycle (bypass) and after.
- With CNT_W=2, alloc $7 three times -> the fourth alloc gives alloc_ready=0 and cnt stays 3. Alloc plus writeback to $7 in the same cycle -> alloc_ready=1 and cnt stays 3.
- alloc $9 and $10, then flush together with wr_en $9=0xAB -> next cycle both not busy and mem[9]=0xAB.
- With REGFILE_TRACE_EN, write $2=0x10 at wr_pc=0x3000 -> exactly one line "@00003000: $ 2 <= 00000010". Writes to $0 and writes during reset print nothing.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned NREAD_DEF  = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [CNT_W_DEF-1:0]  cnt_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Datapath-facing bus of the register file: read ports, writeback, issue allocation and flush.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int unsigned NREAD  = regfile_pkg::NREAD_DEF
);

  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [31:0]             wr_pc;
  logic                    alloc_valid;
  logic [ADDR_W-1:0]       alloc_addr;
  logic                    alloc_ready;
  logic                    flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, alloc_valid, alloc_addr, flush,
    input  rd_data, rd_busy, alloc_ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, alloc_valid, alloc_addr, flush,
    output rd_data, rd_busy, alloc_ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, allocation acceptance and operand busy flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREAD  = NREAD_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  input  logic                    i_alloc_valid,
  input  logic [ADDR_W-1:0]       i_alloc_addr,
  input  logic                    i_flush,
  output logic [NREAD-1:0]        o_rd_busy,
  output logic                    o_alloc_ready
);

  localparam int unsigned     DEPTH   = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt [DEPTH];
  logic              w_alloc_go;
  logic [ADDR_W-1:0] w_a;

  // A saturated counter can still accept when the same register retires this cycle.
  always_comb begin
    o_alloc_ready = (i_alloc_addr == '0) || (r_cnt[i_alloc_addr] != CNT_MAX) ||
                    (i_wr_en && (i_wr_addr == i_alloc_addr));
    w_alloc_go    = i_alloc_valid && o_alloc_ready && (i_alloc_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      for (int unsigned r = 0; r < DEPTH; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (w_alloc_go && (i_alloc_addr == ADDR_W'(r)) &&
            !(i_wr_en && (i_wr_addr == ADDR_W'(r))))
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        else if (i_wr_en && (i_wr_addr == ADDR_W'(r)) && (r_cnt[r] != '0) &&
                 !(w_alloc_go && (i_alloc_addr == ADDR_W'(r))))
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  // The last outstanding write landing this cycle is covered by the bypass.
  always_comb begin
    o_rd_busy = '0;
    w_a       = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      w_a          = i_rd_addr[i*ADDR_W +: ADDR_W];
      o_rd_busy[i] = (w_a != '0) && (r_cnt[w_a] != '0) &&
                     !((r_cnt[w_a] == CNT_W'(1)) && i_wr_en && (i_wr_addr == w_a));
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and pending-write scoreboard.
// Define REGFILE_TRACE_EN to print a trace line for every effective write.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREAD  = NREAD_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [NREAD*DATA_W-1:0] w_rd_data;
  logic [NREAD-1:0]        w_rd_busy;
  logic                    w_alloc_ready;
  logic [ADDR_W-1:0]       w_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) r_mem[r] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en && (bus.wr_addr != '0))
      $display("@%h: $%d <= %h", bus.wr_pc, bus.wr_addr, bus.wr_data);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.wr_pc;
`endif

  // Register 0 reads as zero; a same-cycle writeback is forwarded.
  always_comb begin
    w_rd_data = '0;
    w_a       = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      w_a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (w_a == '0)
        w_rd_data[i*DATA_W +: DATA_W] = '0;
      else if (bus.wr_en && (bus.wr_addr == w_a))
        w_rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
      else
        w_rd_data[i*DATA_W +: DATA_W] = r_mem[w_a];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_rd_addr     (bus.rd_addr),
    .i_wr_en       (bus.wr_en),
    .i_wr_addr     (bus.wr_addr),
    .i_alloc_valid (bus.alloc_valid),
    .i_alloc_addr  (bus.alloc_addr),
    .i_flush       (bus.flush),
    .o_rd_busy     (w_rd_busy),
    .o_alloc_ready (w_alloc_ready)
  );

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.alloc_ready = w_alloc_ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a monitor compares them each cycle.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef struct {
    int          kind;   // 0 rd_data, 1 rd_busy, 2 alloc_ready
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_checks;
  int   n_errors;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

  regfile_sb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_addr     = '0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_pc       = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.flush       = 1'b0;
  endtask

  // Start a new cycle: just after posedge, defaults on all inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int port, input reg_addr_t a);
    bus.rd_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input reg_addr_t a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic alloc(input reg_addr_t a);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = a;
  endtask

  task automatic expect_v(input int kind, input int port, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: at each negedge, drain what the stimulus queued for this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = bus.rd_data[e.port*DATA_W +: DATA_W];
        1:       act = {31'd0, bus.rd_busy[e.port]};
        default: act = {31'd0, bus.alloc_ready};
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s port%0d: got %h expected %h at %0t", e.name, e.port, act, e.val, $time);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr(5'd4, 32'hDEAD_BEEF);   // lost: same cycle as reset
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;

    // Post-reset sweep over every address on both ports.
    for (int a = 0; a < 32; a++) begin
      rd(0, reg_addr_t'(a));
      rd(1, reg_addr_t'(31 - a));
      bus.alloc_addr = reg_addr_t'(a);
      expect_v(0, 0, 32'd0, "reset_data");
      expect_v(0, 1, 32'd0, "reset_data");
      expect_v(1, 0, 32'd0, "reset_busy");
      expect_v(1, 1, 32'd0, "reset_busy");
      expect_v(2, 0, 32'd1, "reset_alloc_ready");
      cyc();
    end

    // Write-through bypass and persistence.
    wr(5'd5, 32'h1234_5678); rd(0, 5'd5);
    expect_v(0, 0, 32'h1234_5678, "bypass_same_cycle");
    cyc(); rd(0, 5'd5); rd(1, 5'd5);
    expect_v(0, 0, 32'h1234_5678, "write_persist");
    expect_v(0, 1, 32'h1234_5678, "write_persist");

    // Register 0 stays zero.
    cyc(); wr(5'd0, 32'hFFFF_FFFF); rd(0, 5'd0);
    expect_v(0, 0, 32'd0, "r0_bypass");
    cyc(); rd(0, 5'd0);
    expect_v(0, 0, 32'd0, "r0_after_write");

    // Alloc then writeback clears busy via bypass.
    cyc(); alloc(5'd3);
    expect_v(2, 0, 32'd1, "alloc3_ready");
    cyc(); rd(0, 5'd3);
    expect_v(1, 0, 32'd1, "r3_busy");
    cyc(); rd(0, 5'd3); wr(5'd3, 32'h0000_0033);
    expect_v(1, 0, 32'd0, "r3_busy_wb_cycle");
    expect_v(0, 0, 32'h0000_0033, "r3_bypass");
    cyc(); rd(0, 5'd3);
    expect_v(1, 0, 32'd0, "r3_busy_after");
    expect_v(0, 0, 32'h0000_0033, "r3_data_after");

    // Saturate counter of $7.
    for (int k = 0; k < 3; k++) begin
      cyc(); alloc(5'd7);
      expect_v(2, 0, 32'd1, "alloc7_ready");
    end
    cyc(); alloc(5'd7); rd(1, 5'd7);
    expect_v(2, 0, 32'd0, "alloc7_full");
    expect_v(1, 1, 32'd1, "r7_busy_full");
    cyc(); alloc(5'd7); wr(5'd7, 32'h77); rd(1, 5'd7);
    expect_v(2, 0, 32'd1, "alloc7_with_wb");
    expect_v(1, 1, 32'd1, "r7_busy_alloc_wb");
    cyc(); bus.alloc_addr = 5'd7; rd(1, 5'd7);
    expect_v(2, 0, 32'd0, "r7_still_full");
    // Drain three writes: busy stays until the last one lands.
    cyc(); wr(5'd7, 32'h71); rd(1, 5'd7);
    expect_v(1, 1, 32'd1, "r7_drain3");
    cyc(); wr(5'd7, 32'h72); rd(1, 5'd7);
    expect_v(1, 1, 32'd1, "r7_drain2");
    cyc(); wr(5'd7, 32'h73); rd(1, 5'd7);
    expect_v(1, 1, 32'd0, "r7_drain1");
    expect_v(0, 1, 32'h73, "r7_last_bypass");
    cyc(); rd(1, 5'd7); bus.alloc_addr = 5'd7;
    expect_v(1, 1, 32'd0, "r7_idle");
    expect_v(2, 0, 32'd1, "r7_ready_again");

    // Flush with simultaneous writeback.
    cyc(); alloc(5'd9);
    cyc(); alloc(5'd10);
    cyc(); bus.flush = 1'b1; wr(5'd9, 32'hAB); rd(1, 5'd10);
    expect_v(1, 1, 32'd1, "r10_busy_pre_flush");
    cyc(); rd(0, 5'd9); rd(1, 5'd10);
    expect_v(1, 0, 32'd0, "r9_flushed");
    expect_v(1, 1, 32'd0, "r10_flushed");
    expect_v(0, 0, 32'hAB, "r9_data_flush");

    // Writeback with no pending alloc must not underflow.
    cyc(); wr(5'd12, 32'h1212);
    cyc(); rd(0, 5'd12);
    expect_v(1, 0, 32'd0, "r12_no_underflow");
    expect_v(0, 0, 32'h1212, "r12_data");

    // Alloc to $0 is accepted and ignored.
    cyc(); alloc(5'd0);
    expect_v(2, 0, 32'd1, "alloc0_ready");
    cyc(); rd(0, 5'd0);
    expect_v(1, 0, 32'd0, "r0_not_busy");

    // Mid-operation reset discards pending state and storage.
    cyc(); alloc(5'd15);
    cyc(); reset = 1'b1; wr(5'd15, 32'h55);
    cyc(); reset = 1'b0; rd(0, 5'd15); rd(1, 5'd5);
    expect_v(1, 0, 32'd0, "r15_busy_after_reset");
    expect_v(0, 0, 32'd0, "r15_data_after_reset");
    expect_v(0, 1, 32'd0, "r5_data_after_reset");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
